// File: rtl/usb_fifo_sched.sv
// usb_fifo_sched: direction scheduler for the FT245-style synchronous USB FIFO bus.
// Arbitrates the shared half-duplex bus between host->device reads and
// device->host writes, limits burst length, inserts the OE turnaround and
// raises a send-immediate pulse once TX traffic has gone quiet.
`timescale 1ns/1ps
module usb_fifo_sched #(
    parameter int MAX_BURST = 64,
    parameter int SIWU_IDLE = 32
) (
    input  logic       usb_clk_60m,
    input  logic       sys_rst_n,
    input  logic       usb_rxf_n,
    input  logic       usb_txe_n,
    input  logic [7:0] usb_data_in,
    output logic       usb_oe_n,
    output logic       usb_rd_n,
    output logic       usb_wr_n,
    output logic [7:0] usb_data_out,
    output logic       usb_siwu_n,
    input  logic       rx_afull,
    output logic       rx_wr_en,
    output logic [7:0] rx_wr_data,
    input  logic       tx_empty,
    input  logic [7:0] tx_rd_data,
    output logic       tx_rd_en,
    output logic       busy
);

    localparam logic [7:0] BURST_LIM = 8'(MAX_BURST);
    localparam logic [7:0] SIWU_LIM  = 8'(SIWU_IDLE);

    typedef enum logic [2:0] {IDLE, RD_OE, RD, TURN, WR} state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] burst_cnt;
    logic       last_dir_rx;
    logic [7:0] idle_cnt;
    logic       pending_flush;

    logic rx_req;
    logic tx_req;
    logic rd_go;
    logic wr_go;
    logic siwu_fire;

    assign rx_req = !usb_rxf_n && !rx_afull;
    assign tx_req = !usb_txe_n && !tx_empty;

    // A strobe is only issued while the partner has room/data and the grant is not used up
    assign rd_go = (state == RD) && rx_req && (burst_cnt < BURST_LIM);
    assign wr_go = (state == WR) && tx_req && (burst_cnt < BURST_LIM);

    // Flush only from IDLE so the pulse never overlaps a bus transaction
    assign siwu_fire = (SIWU_IDLE != 0) && pending_flush && (state == IDLE) && (idle_cnt >= SIWU_LIM);

    assign rx_wr_en     = !usb_rd_n && !usb_rxf_n;
    assign rx_wr_data   = usb_data_in;
    assign tx_rd_en     = wr_go;
    assign usb_data_out = tx_rd_data;
    assign usb_siwu_n   = !siwu_fire;
    assign busy         = (state != IDLE);

    // State register
    always_ff @(posedge usb_clk_60m or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= IDLE;
        else            state <= state_nxt;
    end

    // Next-state selection and bus strobes
    always_comb begin
        state_nxt = state;
        usb_oe_n  = 1'b1;
        usb_rd_n  = 1'b1;
        usb_wr_n  = 1'b1;
        case (state)
            IDLE: begin
                // On a tie the direction not served last wins
                if (rx_req && (!tx_req || !last_dir_rx)) state_nxt = RD_OE;
                else if (tx_req)                         state_nxt = WR;
            end
            RD_OE: begin
                usb_oe_n  = 1'b0;
                state_nxt = RD;
            end
            RD: begin
                usb_oe_n = 1'b0;
                usb_rd_n = !rd_go;
                if (!rd_go) state_nxt = TURN;
            end
            TURN: begin
                state_nxt = IDLE;
            end
            WR: begin
                usb_wr_n = !wr_go;
                if (!wr_go) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Burst length per grant and memory of the last served direction
    always_ff @(posedge usb_clk_60m or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            burst_cnt   <= 8'd0;
            last_dir_rx <= 1'b0;
        end else begin
            if (state == IDLE)      burst_cnt <= 8'd0;
            else if (rd_go || wr_go) burst_cnt <= burst_cnt + 8'd1;
            if (state == RD && !rd_go) last_dir_rx <= 1'b1;
            if (state == WR && !wr_go) last_dir_rx <= 1'b0;
        end
    end

    // Quiet-time tracking after TX words for the send-immediate pulse
    always_ff @(posedge usb_clk_60m or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pending_flush <= 1'b0;
            idle_cnt      <= 8'd0;
        end else if (wr_go) begin
            pending_flush <= 1'b1;
            idle_cnt      <= 8'd0;
        end else if (siwu_fire) begin
            pending_flush <= 1'b0;
            idle_cnt      <= 8'd0;
        end else if (pending_flush && idle_cnt != 8'hFF) begin
            idle_cnt <= idle_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_usb_fifo_sched.sv
// Bench for usb_fifo_sched: bus-level host/FIFO environment, a grant-level
// reference model checked every cycle, and directed scenario expectations.
`timescale 1ns/1ps
module tb_usb_fifo_sched;

    localparam int MAXB = 4;
    localparam int SIWU = 32;

    logic       usb_clk_60m = 1'b0;
    logic       sys_rst_n;
    logic       usb_rxf_n;
    logic       usb_txe_n;
    logic [7:0] usb_data_in;
    logic       usb_oe_n;
    logic       usb_rd_n;
    logic       usb_wr_n;
    logic [7:0] usb_data_out;
    logic       usb_siwu_n;
    logic       rx_afull;
    logic       rx_wr_en;
    logic [7:0] rx_wr_data;
    logic       tx_empty;
    logic [7:0] tx_rd_data;
    logic       tx_rd_en;
    logic       busy;

    always #5 usb_clk_60m = ~usb_clk_60m;

    usb_fifo_sched #(.MAX_BURST(MAXB), .SIWU_IDLE(SIWU)) dut (
        .usb_clk_60m (usb_clk_60m),
        .sys_rst_n   (sys_rst_n),
        .usb_rxf_n   (usb_rxf_n),
        .usb_txe_n   (usb_txe_n),
        .usb_data_in (usb_data_in),
        .usb_oe_n    (usb_oe_n),
        .usb_rd_n    (usb_rd_n),
        .usb_wr_n    (usb_wr_n),
        .usb_data_out(usb_data_out),
        .usb_siwu_n  (usb_siwu_n),
        .rx_afull    (rx_afull),
        .rx_wr_en    (rx_wr_en),
        .rx_wr_data  (rx_wr_data),
        .tx_empty    (tx_empty),
        .tx_rd_data  (tx_rd_data),
        .tx_rd_en    (tx_rd_en),
        .busy        (busy)
    );

    int checks = 0;
    int errors = 0;

    // Environment: host-side byte source, local tx FIFO contents, capture logs
    logic [7:0] host_q[$];
    logic [7:0] tx_q[$];
    logic [7:0] rx_log[$];
    logic [7:0] host_rx[$];
    logic [7:0] dir_log[$];
    bit  afull_knob = 0;
    bit  txe_knob = 0;
    int  afull_after = -1;
    int  txe_after = -1;
    int  rx_cnt_test, tx_cnt_test, tx_pops, oe_low_cnt;
    int  siwu_cnt, siwu_cyc, last_word_cyc, first_oe, first_rd;
    int  cyc = 0;
    bit  rst_pulse_req = 0;

    // Reference model: grant phase, words in this grant, last served direction
    localparam int PH_IDLE = 0, PH_OPEN = 1, PH_READ = 2, PH_TURN = 3, PH_WRITE = 4;
    int m_phase, m_grant, m_word_cyc;
    bit m_last_tx, m_pending, m_rxr, m_txr;
    bit e_oe, e_rd, e_wr, e_siwu, e_rxwe, e_txre, e_busy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_phase = PH_IDLE; m_grant = 0; m_last_tx = 1; m_pending = 0; m_word_cyc = 0;
    endtask

    task automatic drive_inputs();
        usb_rxf_n   = !(host_q.size() > 0);
        usb_data_in = (host_q.size() > 0) ? host_q[0] : 8'h00;
        rx_afull    = afull_knob || (afull_after >= 0 && rx_cnt_test >= afull_after);
        tx_empty    = (tx_q.size() == 0);
        tx_rd_data  = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
        usb_txe_n   = txe_knob || (txe_after >= 0 && tx_cnt_test >= txe_after);
    endtask

    task automatic check_cycle();
        m_rxr = !usb_rxf_n && !rx_afull;
        m_txr = !usb_txe_n && !tx_empty;
        e_oe = 1; e_rd = 1; e_wr = 1; e_siwu = 1; e_rxwe = 0; e_txre = 0; e_busy = 0;
        if (sys_rst_n) begin
            e_busy = (m_phase != PH_IDLE);
            case (m_phase)
                PH_IDLE:  if (SIWU > 0 && m_pending && (cyc - m_word_cyc - 1) >= SIWU) e_siwu = 0;
                PH_OPEN:  e_oe = 0;
                PH_READ: begin
                    e_oe = 0;
                    if (m_rxr && m_grant < MAXB) begin e_rd = 0; e_rxwe = 1; end
                end
                PH_WRITE: if (m_txr && m_grant < MAXB) begin e_wr = 0; e_txre = 1; end
                default: ;
            endcase
        end
        chk("oe_n", usb_oe_n, e_oe);
        chk("rd_n", usb_rd_n, e_rd);
        chk("wr_n", usb_wr_n, e_wr);
        chk("siwu_n", usb_siwu_n, e_siwu);
        chk("rx_wr_en", rx_wr_en, e_rxwe);
        chk("tx_rd_en", tx_rd_en, e_txre);
        chk("busy", busy, e_busy);
        chk("data_out", usb_data_out, tx_rd_data);
        chk("oe_wr_excl", usb_oe_n | usb_wr_n, 1);
        if (e_rxwe) chk("rx_wr_data", rx_wr_data, usb_data_in);
    endtask

    task automatic model_advance(input bit rst_ok);
        if (!rst_ok) begin
            model_reset();
        end else begin
            if (e_txre) begin m_pending = 1; m_word_cyc = cyc; end
            else if (!e_siwu) m_pending = 0;
            case (m_phase)
                PH_IDLE: begin
                    if (m_rxr && (!m_txr || m_last_tx)) begin m_phase = PH_OPEN; m_grant = 0; end
                    else if (m_txr) begin m_phase = PH_WRITE; m_grant = 0; end
                end
                PH_OPEN: m_phase = PH_READ;
                PH_READ: begin
                    if (e_rxwe) m_grant++;
                    else begin m_phase = PH_TURN; m_last_tx = 0; end
                end
                PH_TURN: m_phase = PH_IDLE;
                PH_WRITE: begin
                    if (e_txre) m_grant++;
                    else begin m_phase = PH_IDLE; m_last_tx = 1; end
                end
                default: m_phase = PH_IDLE;
            endcase
        end
    endtask

    task automatic step();
        bit s_rst, s_rd_n, s_rxf_n, s_rxwe, s_wr_n, s_txe_n, s_txre, s_siwu, s_oe;
        logic [7:0] s_rxwd, s_dout;
        @(negedge usb_clk_60m);
        drive_inputs();
        #1;
        check_cycle();
        if (rst_pulse_req) begin
            sys_rst_n = 0;
            #1;
            chk("arst_oe_n", usb_oe_n, 1);
            chk("arst_rd_n", usb_rd_n, 1);
            chk("arst_wr_n", usb_wr_n, 1);
            chk("arst_siwu_n", usb_siwu_n, 1);
            chk("arst_rx_wr_en", rx_wr_en, 0);
            chk("arst_tx_rd_en", tx_rd_en, 0);
            chk("arst_busy", busy, 0);
            rst_pulse_req = 0;
        end
        s_rst = sys_rst_n; s_rd_n = usb_rd_n; s_rxf_n = usb_rxf_n; s_rxwe = rx_wr_en;
        s_rxwd = rx_wr_data; s_wr_n = usb_wr_n; s_txe_n = usb_txe_n; s_dout = usb_data_out;
        s_txre = tx_rd_en; s_siwu = usb_siwu_n; s_oe = usb_oe_n;
        @(posedge usb_clk_60m);
        if (!s_rd_n && !s_rxf_n && host_q.size() > 0) void'(host_q.pop_front());
        if (s_rxwe) begin rx_log.push_back(s_rxwd); dir_log.push_back(8'h52); rx_cnt_test++; end
        if (!s_wr_n && !s_txe_n) begin host_rx.push_back(s_dout); dir_log.push_back(8'h54); last_word_cyc = cyc; end
        if (s_txre) begin
            if (tx_q.size() > 0) void'(tx_q.pop_front());
            tx_pops++; tx_cnt_test++;
        end
        if (!s_siwu) begin siwu_cnt++; siwu_cyc = cyc; end
        if (!s_oe) begin oe_low_cnt++; if (first_oe < 0) first_oe = cyc; end
        if (!s_rd_n && first_rd < 0) first_rd = cyc;
        model_advance(s_rst);
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic release_reset();
        #2 sys_rst_n = 1;
    endtask

    task automatic clear_stats();
        rx_log.delete(); host_rx.delete(); dir_log.delete();
        tx_pops = 0; oe_low_cnt = 0; siwu_cnt = 0; first_oe = -1; first_rd = -1;
        rx_cnt_test = 0; tx_cnt_test = 0; siwu_cyc = -1; last_word_cyc = -1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        sys_rst_n = 0;
        model_reset();
        clear_stats();
        drive_inputs();
        #2;
        chk("rst_oe_n", usb_oe_n, 1);
        chk("rst_rd_n", usb_rd_n, 1);
        chk("rst_wr_n", usb_wr_n, 1);
        chk("rst_siwu_n", usb_siwu_n, 1);
        chk("rst_rx_wr_en", rx_wr_en, 0);
        chk("rst_tx_rd_en", tx_rd_en, 0);
        chk("rst_busy", busy, 0);
        run(2);
        release_reset();

        // Read path: ten host bytes 0x00..0x09
        clear_stats();
        for (int i = 0; i < 10; i++) host_q.push_back(8'(i));
        run(40);
        chk("rd_count", rx_log.size(), 10);
        if (rx_log.size() == 10)
            for (int i = 0; i < 10; i++) chk("rd_data", rx_log[i], i);
        chk("oe_leads_rd", first_rd - first_oe, 1);

        // Write path: five words 0xA0..0xA4
        clear_stats();
        for (int i = 0; i < 5; i++) tx_q.push_back(8'hA0 + 8'(i));
        run(20);
        chk("wr_count", host_rx.size(), 5);
        if (host_rx.size() == 5)
            for (int i = 0; i < 5; i++) chk("wr_data", host_rx[i], 8'hA0 + i);
        chk("wr_pops", tx_pops, 5);
        chk("wr_oe_quiet", oe_low_cnt, 0);
        run(40);
        chk("wr_siwu_pulses", siwu_cnt, 1);

        // Contention: both directions loaded, bursts of four alternate starting with RX
        clear_stats();
        for (int i = 0; i < 8; i++) begin
            host_q.push_back(8'h10 + 8'(i));
            tx_q.push_back(8'hB0 + 8'(i));
        end
        run(45);
        chk("cont_words", dir_log.size(), 16);
        if (dir_log.size() == 16)
            for (int i = 0; i < 16; i++) chk("cont_dir", dir_log[i], ((i / 4) % 2 == 0) ? 8'h52 : 8'h54);
        run(45);

        // Backpressure: rx FIFO nearly full after three reads
        clear_stats();
        afull_after = 3;
        for (int i = 0; i < 6; i++) host_q.push_back(8'h20 + 8'(i));
        run(15);
        chk("bp_count", rx_log.size(), 3);
        #1;
        chk("bp_idle", busy, 0);
        afull_after = -1;
        run(20);
        chk("bp_total", rx_log.size(), 6);
        if (rx_log.size() == 6) chk("bp_last", rx_log[5], 8'h25);

        // Asynchronous reset during a read burst
        clear_stats();
        for (int i = 0; i < 6; i++) host_q.push_back(8'h30 + 8'(i));
        run(3);
        chk("arst_pre_words", rx_log.size(), 1);
        tx_q.push_back(8'hD0);
        tx_q.push_back(8'hD1);
        rst_pulse_req = 1;
        run(3);
        release_reset();
        rx_log.delete(); dir_log.delete();
        run(30);
        chk("arst_words", dir_log.size(), 7);
        if (dir_log.size() > 0) chk("arst_rx_first", dir_log[0], 8'h52);
        if (rx_log.size() > 0) chk("arst_resume_data", rx_log[0], 8'h31);
        run(45);

        // TXE deasserts after two words; then send-immediate after 32 quiet cycles
        clear_stats();
        txe_after = 2;
        for (int i = 0; i < 5; i++) tx_q.push_back(8'hC0 + 8'(i));
        run(45);
        chk("txe_pops", tx_pops, 2);
        chk("txe_words", host_rx.size(), 2);
        chk("txe_siwu_pulses", siwu_cnt, 1);
        chk("txe_siwu_gap", siwu_cyc - last_word_cyc - 1, 32);
        txe_after = -1;
        run(15);
        chk("txe_resume_pops", tx_pops, 5);
        run(45);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/usb_fifo_sched.md
Name: usb_fifo_sched

Overview:
- Bus scheduler for the FT245-style synchronous USB FIFO interface, clocked by the 60 MHz USB clock.
- Shares the single half-duplex 8-bit bus between the host-to-device path (RX: into the local rx FIFO) and the device-to-host path (TX: out of the local tx FIFO).
- Provides round-robin direction arbitration, burst limiting, OE turnaround and send-immediate (SIWU) flushing.
- Sits between the USB pins and the rx/tx buffer FIFOs inside usb_top.

Parameters:
- MAX_BURST, 64, max words moved per grant before re-arbitration (1..255).
- SIWU_IDLE, 32, idle cycles after the last TX word before a SIWU pulse; 0 disables SIWU.

Ports:
- usb_clk_60m  in  1  single clock, rising edge.
- sys_rst_n  in  1  asynchronous active-low reset.
- usb_rxf_n  in  1  low = host data available.
- usb_txe_n  in  1  low = device may write.
- usb_data_in  in  8  bus read data.
- usb_oe_n  out  1  bus output-enable to chip, low during read.
- usb_rd_n  out  1  read strobe, low active.
- usb_wr_n  out  1  write strobe, low active.
- usb_data_out  out  8  bus write data.
- usb_siwu_n  out  1  send-immediate, low pulse.
- rx_afull  in  1  rx FIFO has fewer than 4 free entries.
- rx_wr_en  out  1  rx FIFO write strobe.
- rx_wr_data  out  8  rx FIFO write data.
- tx_empty  in  1  tx FIFO empty (show-ahead FIFO).
- tx_rd_data  in  8  tx FIFO head word, valid when !tx_empty.
- tx_rd_en  out  1  tx FIFO pop.
- busy  out  1  state != IDLE.

Behaviour:
- Requests:
  - rx_req = !usb_rxf_n && !rx_afull.
  - tx_req = !usb_txe_n && !tx_empty.
- Reset values:
  - usb_oe_n = usb_rd_n = usb_wr_n = usb_siwu_n = 1.
  - rx_wr_en = tx_rd_en = 0; busy = 0.
  - State IDLE, burst_cnt = 0, last_dir = TX (so RX wins the first tie), idle_cnt = 0, pending_flush = 0.
- States: IDLE, RD_OE, RD, TURN, WR.
- IDLE:
  - Only rx_req -> RD_OE. Only tx_req -> WR.
  - Both requesting -> the direction opposite last_dir.
  - Neither -> stay in IDLE.
  - burst_cnt is cleared on every exit from IDLE.
- RD_OE: exactly 1 cycle. usb_oe_n = 0, usb_rd_n = 1. Always -> RD.
- RD:
  - usb_oe_n = 0.
  - usb_rd_n = 0 while rx_req is true and burst_cnt < MAX_BURST; otherwise 1.
  - Each cycle where !usb_rd_n && !usb_rxf_n: rx_wr_en = 1, rx_wr_data = usb_data_in (combinational, same edge), and burst_cnt increments.
  - When usb_rd_n would be 1 (rxf_n high, rx_afull, or burst_cnt == MAX_BURST): -> TURN; set last_dir = RX.
- TURN: exactly 1 cycle. usb_oe_n = 1, usb_rd_n = 1. -> IDLE.
- WR:
  - usb_wr_n = 0 and tx_rd_en = 1 while tx_req is true and burst_cnt < MAX_BURST.
  - usb_data_out = tx_rd_data in all states; the bus is only qualified by usb_wr_n.
  - Each accepted word increments burst_cnt.
  - Exit when the strobe condition is false -> IDLE; set last_dir = TX.
  - A word is transferred only in a cycle with usb_wr_n = 0 and usb_txe_n = 0. txe_n rising mid-burst ends the burst with no word lost.
- Arbitration:
  - RD -> TX always passes through TURN, so there is a minimum 1-cycle gap with oe_n high before wr_n may fall.
  - WR -> RD always passes through RD_OE.
  - oe_n and wr_n are never low in the same cycle.
- SIWU:
  - Each TX word sets pending_flush = 1 and clears idle_cnt.
  - While pending_flush is set and no word is written, idle_cnt increments (saturating).
  - When idle_cnt reaches SIWU_IDLE and state is IDLE: usb_siwu_n = 0 for exactly 1 cycle, then pending_flush = 0 and idle_cnt = 0.
  - If TX re-enters WR before the threshold, no pulse occurs.
  - SIWU_IDLE = 0: usb_siwu_n is held at 1.
- Widths: burst_cnt is 8 bits; idle_cnt is 8 bits and saturates at 255.
- Asynchronous reset mid-burst: all strobes return to 1 immediately; no rx_wr_en or tx_rd_en is emitted while reset is asserted.
- busy = 1 in every state other than IDLE.

Test Plan:
- Read path: rxf_n low for 10 cycles, rx_afull = 0 -> oe_n falls 1 cycle before rd_n; 10 rx_wr_en pulses capturing 0x00..0x09; TURN cycle; back to IDLE.
- Write path: tx FIFO holds 5 words 0xA0..0xA4, txe_n low -> wr_n low 5 cycles; usb_data_out is 0xA0..0xA4; 5 tx_rd_en pulses; oe_n stays 1.
- Contention with MAX_BURST = 4: rxf_n and txe_n both low, both FIFOs non-empty -> bursts alternate RD(4), TURN, WR(4), RD_OE, RD(4)...; oe_n and wr_n never low together.
- Backpressure: rx_afull rises after 3 reads -> rd_n rises the same cycle; exactly 3 words written; -> TURN.
- txe_n rises mid-write after 2 words -> exactly 2 tx_rd_en pulses; pending_flush set; siwu_n low for 1 cycle SIWU_IDLE = 32 cycles after the last word.
- Assert sys_rst_n low during an RD burst -> all strobes are 1 immediately; after release, the sequence restarts from IDLE with RX priority.
